lse_css_monitor: RTL and testbench

LSE clock security system (CSS) monitor for the VSW/backup domain. It runs on the LSI clock and watches a divided LSE toggle for activity. When LSE activity stops, it raises the sticky lsecss_fail flag. The RTC kernel-clock switch consumes that flag to drop the LSE source. It also issues a one-cycle interrupt pulse to the RCC register/IRQ logic.

---
 rtl/lse_css_monitor.sv | 116 +++++++++++
 tb/tb_lse_css_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lse_css_monitor.sv
// LSE clock security monitor: watches a synchronised LSE/4 toggle from the LSI domain
// and latches a sticky failure when activity stops for TIMEOUT cycles.
module lse_css_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned ARM_DLY     = 8,
    parameter int unsigned CNT_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic lse_div_tgl,
    input  logic lseon,
    input  logic lserdy,
    input  logic lsecsson,
    output logic lsecss_fail,
    output logic lsecss_irq,
    output logic lsecss_active
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StArm     = 2'd1;
    localparam logic [1:0] StMonitor = 2'd2;
    localparam logic [1:0] StFail    = 2'd3;

    localparam logic [CNT_W-1:0] ArmLast     = CNT_W'(ARM_DLY - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax      = '1;

    if (SYNC_STAGES < 2 || TIMEOUT < 4 || ARM_DLY < 1 ||
        (2 ** CNT_W) <= TIMEOUT || (2 ** CNT_W) <= ARM_DLY) begin : gen_bad_params
        $error("lse_css_monitor: illegal parameter set");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   lse_edge;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   css_en_q;
    logic                   fail_q, irq_q, active_q;

    assign lse_edge = sync_q[SYNC_STAGES-1] ^ hist_q;
    assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (css_en_q && lseon) state_d = StArm;
            end
            StArm: begin
                if (!lseon) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (!lserdy) begin
                    cnt_d = '0;
                end else if (cnt_q == ArmLast) begin
                    state_d = StMonitor;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StMonitor: begin
                // An edge on the last count wins over the timeout.
                if (!lseon) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (lse_edge) begin
                    cnt_d = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StFail;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            css_en_q <= 1'b0;
            fail_q   <= 1'b0;
            irq_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], lse_div_tgl};
            hist_q   <= sync_q[SYNC_STAGES-1];
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            css_en_q <= css_en_q | lsecsson;
            fail_q   <= (state_d == StFail);
            irq_q    <= (state_q == StMonitor) && (state_d == StFail);
            active_q <= (state_d == StMonitor);
        end
    end

    assign lsecss_fail   = fail_q;
    assign lsecss_irq    = irq_q;
    assign lsecss_active = active_q;

endmodule

// File: tb/tb_lse_css_monitor.sv
// Bench for lse_css_monitor: directed test-plan scenarios plus a randomized phase,
// all checked against a cycle-count reference model.
module tb_lse_css_monitor;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TIMEOUT     = 16;
    localparam int unsigned ARM_DLY     = 8;
    localparam int unsigned CNT_W       = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lse_div_tgl = 1'b0;
    logic lseon = 1'b1;
    logic lserdy = 1'b1;
    logic lsecsson = 1'b1;
    logic lsecss_fail, lsecss_irq, lsecss_active;

    int n_checks = 0;
    int n_errors = 0;
    int period = 4;
    int phase = 0;

    always #5 clk = ~clk;

    lse_css_monitor #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT),
        .ARM_DLY    (ARM_DLY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lse_div_tgl  (lse_div_tgl),
        .lseon        (lseon),
        .lserdy       (lserdy),
        .lsecsson     (lsecsson),
        .lsecss_fail  (lsecss_fail),
        .lsecss_irq   (lsecss_irq),
        .lsecss_active(lsecss_active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: counts consecutive ready cycles and quiet cycles since the last
    // synchronised LSE transition.
    localparam int MIdle = 0, MArm = 1, MMon = 2, MFail = 3;
    int m_mode = MIdle;
    int m_run = 0;
    int m_quiet = 0;
    bit m_css_en = 1'b0;
    bit m_irq = 1'b0;
    bit tq [SYNC_STAGES+2];

    task automatic model_step();
        bit seen;
        for (int k = SYNC_STAGES + 1; k > 0; k--) tq[k] = tq[k-1];
        tq[0] = lse_div_tgl;
        seen  = tq[SYNC_STAGES] ^ tq[SYNC_STAGES+1];
        m_irq = 1'b0;
        if (rst) begin
            for (int k = 0; k <= SYNC_STAGES; k++) tq[k] = 1'b0;
            m_mode = MIdle;
            m_css_en = 1'b0;
            m_run = 0;
            m_quiet = 0;
        end else begin
            case (m_mode)
                MIdle: if (m_css_en && lseon) begin
                    m_mode = MArm;
                    m_run = 0;
                end
                MArm: begin
                    if (!lseon) m_mode = MIdle;
                    else if (lserdy) begin
                        m_run++;
                        if (m_run == ARM_DLY) begin
                            m_mode = MMon;
                            m_quiet = 0;
                        end
                    end else m_run = 0;
                end
                MMon: begin
                    if (!lseon) m_mode = MIdle;
                    else if (seen) m_quiet = 0;
                    else begin
                        m_quiet++;
                        if (m_quiet == TIMEOUT) begin
                            m_mode = MFail;
                            m_irq = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (lsecsson) m_css_en = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("model_fail", {31'd0, lsecss_fail}, {31'd0, m_mode == MFail});
        check("model_irq", {31'd0, lsecss_irq}, {31'd0, m_irq});
        check("model_active", {31'd0, lsecss_active}, {31'd0, m_mode == MMon});
    end

    task automatic step();
        @(negedge clk);
        if (period > 0) begin
            phase++;
            if (phase >= period) begin
                phase = 0;
                lse_div_tgl = ~lse_div_tgl;
            end
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_active(output int k);
        k = 0;
        while (!lsecss_active && k < 64) begin
            step();
            k++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {29'd0, lsecss_fail, lsecss_irq, lsecss_active}, 32'd0);
    endtask

    initial begin
        int k;
        bit any_fail;
        bit all_fail;

        // Reset and nominal arming
        steps(3);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        wait_active(k);
        check("nominal_arm_latency", k, ARM_DLY + 2);
        any_fail = 1'b0;
        repeat (1000) begin
            step();
            any_fail |= lsecss_fail;
        end
        check("nominal_no_fail", {31'd0, any_fail}, 32'd0);

        // Stop detect
        period = 0;
        step();
        lse_div_tgl = ~lse_div_tgl;
        k = 0;
        while (!lsecss_fail && k < 100) begin
            step();
            k++;
        end
        check("stop_latency", k, SYNC_STAGES + 1 + TIMEOUT);
        check("stop_irq_first", {31'd0, lsecss_irq}, 32'd1);
        check("stop_active_low", {31'd0, lsecss_active}, 32'd0);
        step();
        check("stop_irq_single", {31'd0, lsecss_irq}, 32'd0);

        // Sticky failure ignores disable and restarted toggles
        lseon = 1'b0;
        lsecsson = 1'b0;
        period = 3;
        all_fail = 1'b1;
        repeat (50) begin
            step();
            all_fail &= lsecss_fail;
        end
        check("sticky_fail", {31'd0, all_fail}, 32'd1);

        // Reset during FAIL, then re-arm
        rst = 1'b1;
        step();
        check_all_zero("reset_in_fail");
        rst = 1'b0;
        lseon = 1'b1;
        lsecsson = 1'b1;
        period = 4;
        wait_active(k);
        check("rearm_after_fail", k, ARM_DLY + 2);

        // Boundary race: spacing TIMEOUT survives, TIMEOUT+1 fails
        period = TIMEOUT;
        steps(10 * TIMEOUT);
        check("race_no_fail", {30'd0, lsecss_fail, lsecss_active}, 32'd1);
        period = TIMEOUT + 1;
        steps(3 * (TIMEOUT + 1));
        check("race_fail", {31'd0, lsecss_fail}, 32'd1);

        // Arm gating with a lserdy glitch
        rst = 1'b1;
        lserdy = 1'b0;
        period = 4;
        step();
        rst = 1'b0;
        steps(3);
        lserdy = 1'b1;
        steps(5);
        lserdy = 1'b0;
        step();
        check("gate_not_active", {31'd0, lsecss_active}, 32'd0);
        lserdy = 1'b1;
        wait_active(k);
        check("gate_latency", k, ARM_DLY);

        // Disable in MONITOR, then re-arm on sticky css_en
        steps(20);
        lseon = 1'b0;
        step();
        check("disable_idle", {30'd0, lsecss_fail, lsecss_active}, 32'd0);
        lsecsson = 1'b0;
        steps(2);
        lseon = 1'b1;
        wait_active(k);
        check("sticky_en_rearm", k, ARM_DLY + 1);

        // Reset during ARM
        lseon = 1'b0;
        step();
        lseon = 1'b1;
        steps(3);
        rst = 1'b1;
        step();
        check_all_zero("reset_in_arm");
        rst = 1'b0;
        lsecsson = 1'b1;
        wait_active(k);
        check("rearm_after_arm_reset", k, ARM_DLY + 2);

        // Randomized phase
        repeat (200) begin
            period   = $urandom_range(0, TIMEOUT + 3);
            lseon    = ($urandom_range(0, 9) != 0);
            lserdy   = ($urandom_range(0, 5) != 0);
            lsecsson = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            steps($urandom_range(1, 40));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
